// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the WISC pipeline.
// Owns the PC, the handshaked instruction-memory request, a one-entry skid
// buffer for data that lands while decode is stalled, and the IF/ID pipeline
// register. Later stages feed back halt, siic, rti, redirect and stall.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        siic,
  input  logic        rti,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] instr,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic [15:0] epc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH      = 2'd0,
    S_DISCARD    = 2'd1,
    S_DRAIN_HALT = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] addr_r, addr_s;
  logic        req_r, req_s;
  logic [15:0] instr_r, instr_s;
  logic [15:0] pp2_r, pp2_s;
  logic        valid_r, valid_s;
  logic [15:0] epc_r, epc_s;
  logic        halted_r, halted_s;
  logic        skid_full_r, skid_full_s;
  logic [15:0] skid_instr_r, skid_instr_s;
  logic [15:0] skid_pp2_r, skid_pp2_s;

  logic        done_s;
  logic        busy_s;
  logic [15:0] pc_inc_s;
  logic        jump_s;
  logic [15:0] target_s;

  // Handshake status of the access currently on the bus and the sequential PC.
  always_comb begin
    done_s   = req_r & imem_ready;
    busy_s   = req_r & ~imem_ready;
    pc_inc_s = pc_r + 16'h0002;
    jump_s   = siic | rti | redirect;
  end

  // Fetch target for the highest-priority PC-changing event (siic > rti > redirect).
  always_comb begin
    target_s = redirect_pc;
    if (siic) begin
      target_s = EXC_VECTOR;
    end else if (rti) begin
      target_s = epc_r;
    end else begin
      target_s = redirect_pc;
    end
  end

  // Next-state and next-register logic; every register holds unless a branch updates it.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    addr_s       = addr_r;
    req_s        = req_r;
    instr_s      = instr_r;
    pp2_s        = pp2_r;
    valid_s      = valid_r;
    epc_s        = epc_r;
    halted_s     = halted_r;
    skid_full_s  = skid_full_r;
    skid_instr_s = skid_instr_r;
    skid_pp2_s   = skid_pp2_r;

    case (state_r)
      S_FETCH, S_DISCARD: begin
        if (halt) begin
          // Any completing data is dropped; an open access must still finish.
          instr_s     = NOP_INSTR;
          valid_s     = 1'b0;
          skid_full_s = 1'b0;
          if (busy_s) begin
            state_s = S_DRAIN_HALT;
          end else begin
            state_s  = S_HALTED;
            req_s    = 1'b0;
            halted_s = 1'b1;
          end
        end else if (jump_s) begin
          instr_s     = NOP_INSTR;
          valid_s     = 1'b0;
          skid_full_s = 1'b0;
          pc_s        = target_s;
          if (siic) begin
            epc_s = pp2_r;
          end else begin
            epc_s = epc_r;
          end
          if (busy_s) begin
            // Address must stay put until the old access completes.
            state_s = S_DISCARD;
          end else begin
            state_s = S_FETCH;
            addr_s  = target_s;
            req_s   = 1'b1;
          end
        end else if (state_r == S_DISCARD) begin
          // Wrong-path access: throw its data away, then start at the saved target.
          if (done_s) begin
            state_s = S_FETCH;
            addr_s  = pc_r;
            req_s   = 1'b1;
          end else begin
            state_s = S_DISCARD;
          end
        end else if (stall) begin
          // IF/ID frozen; a word that lands now is parked in the skid buffer.
          if (done_s) begin
            skid_full_s  = 1'b1;
            skid_instr_s = imem_rdata;
            skid_pp2_s   = pc_inc_s;
            pc_s         = pc_inc_s;
            addr_s       = pc_inc_s;
            req_s        = 1'b0;
          end else if (skid_full_r) begin
            req_s = 1'b0;
          end else if (!req_r) begin
            req_s  = 1'b1;
            addr_s = pc_r;
          end else begin
            req_s = req_r;
          end
        end else if (skid_full_r) begin
          // Stall released: the parked word goes ahead of any new fetch.
          instr_s     = skid_instr_r;
          pp2_s       = skid_pp2_r;
          valid_s     = 1'b1;
          skid_full_s = 1'b0;
          req_s       = 1'b1;
          addr_s      = pc_r;
        end else if (done_s) begin
          instr_s = imem_rdata;
          pp2_s   = pc_inc_s;
          valid_s = 1'b1;
          pc_s    = pc_inc_s;
          addr_s  = pc_inc_s;
          req_s   = 1'b1;
        end else begin
          // Nothing arrived: hand decode a bubble and keep (or start) the access.
          instr_s = NOP_INSTR;
          valid_s = 1'b0;
          req_s   = 1'b1;
          if (busy_s) begin
            addr_s = addr_r;
          end else begin
            addr_s = pc_r;
          end
        end
      end

      S_DRAIN_HALT: begin
        // Inputs are ignored; only the outstanding access is allowed to finish.
        instr_s = NOP_INSTR;
        valid_s = 1'b0;
        if (done_s) begin
          state_s  = S_HALTED;
          req_s    = 1'b0;
          halted_s = 1'b1;
        end else begin
          state_s = S_DRAIN_HALT;
        end
      end

      S_HALTED: begin
        instr_s  = NOP_INSTR;
        valid_s  = 1'b0;
        req_s    = 1'b0;
        halted_s = 1'b1;
      end

      default: begin
        state_s     = S_FETCH;
        pc_s        = RESET_PC;
        addr_s      = RESET_PC;
        req_s       = 1'b0;
        instr_s     = NOP_INSTR;
        valid_s     = 1'b0;
        halted_s    = 1'b0;
        skid_full_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_FETCH;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      req_r        <= 1'b0;
      instr_r      <= NOP_INSTR;
      pp2_r        <= 16'h0000;
      valid_r      <= 1'b0;
      epc_r        <= 16'h0000;
      halted_r     <= 1'b0;
      skid_full_r  <= 1'b0;
      skid_instr_r <= NOP_INSTR;
      skid_pp2_r   <= 16'h0000;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      addr_r       <= addr_s;
      req_r        <= req_s;
      instr_r      <= instr_s;
      pp2_r        <= pp2_s;
      valid_r      <= valid_s;
      epc_r        <= epc_s;
      halted_r     <= halted_s;
      skid_full_r  <= skid_full_s;
      skid_instr_r <= skid_instr_s;
      skid_pp2_r   <= skid_pp2_s;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    imem_req    = req_r;
    imem_addr   = addr_r;
    instr       = instr_r;
    pc_plus2    = pp2_r;
    instr_valid = valid_r;
    epc         = epc_r;
    halted      = halted_r;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table for streaming,
// stall/skid, redirect, siic/rti, wrap and wait-state discard, plus hand-written
// halt-drain and asynchronous-reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        siic = 1'b0;
  logic        rti = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        instr_valid;
  logic [15:0] epc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .siic(siic), .rti(rti), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .instr(instr), .pc_plus2(pc_plus2),
    .instr_valid(instr_valid), .epc(epc), .halted(halted)
  );

  // Memory returns a word derived from its address.
  assign imem_rdata = imem_addr | 16'hA000;

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        siic;
    logic        rti;
    logic        halt;
    logic        ready;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pp2;
    logic        e_valid;
    logic [15:0] e_epc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] rp,
                       input logic si, input logic rt, input logic h, input logic rd);
    stall = s; redirect = r; redirect_pc = rp; siic = si; rti = rt; halt = h; imem_ready = rd;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},    {15'd0, imem_req},    16'h0000);
    chk({tag, ".addr"},   imem_addr,            16'h0000);
    chk({tag, ".instr"},  instr,                16'h0800);
    chk({tag, ".pp2"},    pc_plus2,             16'h0000);
    chk({tag, ".valid"},  {15'd0, instr_valid}, 16'h0000);
    chk({tag, ".epc"},    epc,                  16'h0000);
    chk({tag, ".halted"}, {15'd0, halted},      16'h0000);
  endtask

  initial begin
    // stall redir rpc siic rti halt ready | req addr instr pp2 valid epc
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0000,16'h0800,16'h0000,1'b0,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0002,16'hA000,16'h0002,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0004,16'hA002,16'h0004,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0006,16'hA004,16'h0006,1'b1,16'h0000});
    vecs.push_back('{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b0,16'h0008,16'hA004,16'h0006,1'b1,16'h0000});
    vecs.push_back('{1'b1,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b0,16'h0008,16'hA004,16'h0006,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0008,16'hA006,16'h0008,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h000A,16'hA008,16'h000A,1'b1,16'h0000});
    vecs.push_back('{1'b1,1'b1,16'h0200,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0200,16'h0800,16'h000A,1'b0,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0202,16'hA200,16'h0202,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b1,16'hFFFE,1'b0,1'b0,1'b0,1'b1, 1'b1,16'hFFFE,16'h0800,16'h0202,1'b0,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0000,16'hFFFE,16'h0000,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0002,16'hA000,16'h0002,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b1,16'h0012,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0012,16'h0800,16'h0002,1'b0,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0014,16'hA012,16'h0014,1'b1,16'h0000});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b1, 1'b1,16'h0002,16'h0800,16'h0014,1'b0,16'h0014});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0004,16'hA002,16'h0004,1'b1,16'h0014});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b1, 1'b1,16'h0014,16'h0800,16'h0004,1'b0,16'h0014});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0016,16'hA014,16'h0016,1'b1,16'h0014});
    vecs.push_back('{1'b0,1'b1,16'h0300,1'b1,1'b0,1'b0,1'b1, 1'b1,16'h0002,16'h0800,16'h0016,1'b0,16'h0016});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0004,16'hA002,16'h0004,1'b1,16'h0016});
    vecs.push_back('{1'b0,1'b1,16'h0008,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0008,16'h0800,16'h0004,1'b0,16'h0016});
    vecs.push_back('{1'b0,1'b1,16'h0100,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0008,16'h0800,16'h0004,1'b0,16'h0016});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0008,16'h0800,16'h0004,1'b0,16'h0016});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0008,16'h0800,16'h0004,1'b0,16'h0016});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0100,16'h0800,16'h0004,1'b0,16'h0016});
    vecs.push_back('{1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b1,16'h0102,16'hA100,16'h0102,1'b1,16'h0016});

    // Reset held across two clock edges, then released just after an edge.
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;

    // Table: inputs applied before each edge, registered outputs checked after it.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].siic,
            vecs[i].rti, vecs[i].halt, vecs[i].ready);
      step();
      chk($sformatf("v%0d.req", i),    {15'd0, imem_req},    {15'd0, vecs[i].e_req});
      chk($sformatf("v%0d.addr", i),   imem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d.instr", i),  instr,                vecs[i].e_instr);
      chk($sformatf("v%0d.pp2", i),    pc_plus2,             vecs[i].e_pp2);
      chk($sformatf("v%0d.valid", i),  {15'd0, instr_valid}, {15'd0, vecs[i].e_valid});
      chk($sformatf("v%0d.epc", i),    epc,                  vecs[i].e_epc);
      chk($sformatf("v%0d.halted", i), {15'd0, halted},      16'h0000);
    end

    // Halt while the access to 0x0102 is waiting: drain, then stop for good.
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk("drain0.req",    {15'd0, imem_req},    16'h0001);
    chk("drain0.addr",   imem_addr,            16'h0102);
    chk("drain0.valid",  {15'd0, instr_valid}, 16'h0000);
    chk("drain0.instr",  instr,                16'h0800);
    chk("drain0.halted", {15'd0, halted},      16'h0000);
    drive(1'b0, 1'b1, 16'h0400, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drain1.req",    {15'd0, imem_req},    16'h0001);
    chk("drain1.addr",   imem_addr,            16'h0102);
    chk("drain1.halted", {15'd0, halted},      16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("halted.req",    {15'd0, imem_req},    16'h0000);
    chk("halted.halted", {15'd0, halted},      16'h0001);
    chk("halted.valid",  {15'd0, instr_valid}, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      drive(i[0], i[1], 16'h0500, i[2], i[0], 1'b0, 1'b1);
      step();
      chk($sformatf("hold%0d.req", i),    {15'd0, imem_req},    16'h0000);
      chk($sformatf("hold%0d.halted", i), {15'd0, halted},      16'h0001);
      chk($sformatf("hold%0d.valid", i),  {15'd0, instr_valid}, 16'h0000);
      chk($sformatf("hold%0d.instr", i),  instr,                16'h0800);
      chk($sformatf("hold%0d.epc", i),    epc,                  16'h0016);
    end

    // Asynchronous reset mid-cycle while halted: outputs clear before any edge.
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst_halted");

    // Rerun: fetch once, halt into DRAIN_HALT, reset in the middle of the drain.
    step();
    rst = 1'b0;
    step();
    chk("rerun.req",  {15'd0, imem_req}, 16'h0001);
    chk("rerun.addr", imem_addr,         16'h0000);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("rdrain.req",    {15'd0, imem_req}, 16'h0001);
    chk("rdrain.halted", {15'd0, halted},   16'h0000);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("arst_drain");

    // After release, fetching restarts from the reset PC.
    step();
    rst = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("restart.req",  {15'd0, imem_req}, 16'h0001);
    chk("restart.addr", imem_addr,         16'h0000);
    step();
    chk("restart.instr", instr,                16'hA000);
    chk("restart.valid", {15'd0, instr_valid}, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
